memref_bram_responder: RTL

- Synthesizable responder for the HIR memref single-port protocol (addr_en/addr_data/rd_en/rd_data/wr_en/wr_data) driven by generated kernels such as unsharp_mask_hir.
- Replaces the behavioural memref_rd/memref_wr bench models with a BRAM-backed slave for FPGA and co-simulation.
- Adds a host-side preload stream (INIT) and a host-side readback stream (DUMP).

---
 rtl/memref_bram_responder_if.sv | 25 ++
 rtl/memref_bram_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/memref_bram_responder_if.sv
// Kernel-side HIR memref single-port bus: address, read request/response, write request.
`timescale 1ns/1ps

interface memref_bram_responder_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  logic              addr_en;
  logic [ADDR_W-1:0] addr_data;
  logic              rd_en;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;

  modport master (
    output addr_en, addr_data, rd_en, wr_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  addr_en, addr_data, rd_en, wr_en, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/memref_bram_responder.sv
// BRAM-backed responder for the HIR memref port, with host preload (INIT) and
// readback (DUMP) streams around the kernel-facing SERVE phase.
`timescale 1ns/1ps

module memref_bram_responder #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 1024,
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  memref_bram_responder_if.slave p0,
  input  logic                   init_valid,
  input  logic [WIDTH-1:0]       init_data,
  output logic                   init_ready,
  input  logic                   init_bypass,
  output logic                   serve,
  input  logic                   dump_start,
  output logic                   dump_valid,
  output logic [WIDTH-1:0]       dump_data,
  output logic                   dump_last,
  input  logic                   dump_ready,
  output logic                   err
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic [1:0]       WAIT_END = 2'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SERVE,
    ST_DUMP_RD,
    ST_DUMP_OUT
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] cnt_reg;
  logic [IDX_W-1:0] dcnt_reg;
  logic [1:0]       wait_reg;
  logic             dump_pend_reg;
  logic [WIDTH-1:0] dump_word_reg;

  logic [WIDTH-1:0] mem [SIZE];

  logic                  in_serve;
  logic                  addr_oob;
  logic [IDX_W-1:0]      addr_idx;
  logic                  kern_rd;
  logic                  kern_wr;
  logic                  init_wr;
  logic                  dump_rd;
  logic                  dump_go;
  logic                  proto_err;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  unused_addr_en;

  // addr_en only qualifies the address for the kernel; decode uses rd_en/wr_en.
  assign unused_addr_en = p0.addr_en;

  assign in_serve  = (state_reg == ST_SERVE);
  assign addr_oob  = (32'(p0.addr_data) >= 32'(SIZE));
  assign addr_idx  = p0.addr_data[IDX_W-1:0];
  assign kern_rd   = in_serve & p0.rd_en;
  assign kern_wr   = in_serve & p0.wr_en & ~addr_oob;
  assign init_wr   = (state_reg == ST_INIT) & init_valid & ~init_bypass;
  assign dump_rd   = (state_reg == ST_DUMP_RD) && (wait_reg == 2'd0);
  assign dump_go   = in_serve & (dump_pend_reg | dump_start) & ~(|pipe_valid) & ~p0.rd_en;
  assign proto_err = (in_serve & p0.rd_en & p0.wr_en)
                   | (in_serve & (p0.rd_en | p0.wr_en) & addr_oob)
                   | (~in_serve & (p0.rd_en | p0.wr_en));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_reg;
    mem_wdata = init_data;
    if (init_wr) begin
      mem_we = 1'b1;
    end else if (kern_wr) begin
      mem_we    = 1'b1;
      mem_waddr = addr_idx;
      mem_wdata = p0.wr_data;
    end
  end

  // Contents survive reset; same-edge reads see the pre-write word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_word_reg <= '0;
    end else if (dump_rd) begin
      dump_word_reg <= mem[dcnt_reg];
    end
  end

  // Fixed-latency read pipeline; each stage only loads on a valid word so the
  // output holds its last value between responses.
  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;

      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
          end else begin
            valid_reg <= kern_rd;
            if (kern_rd) begin
              data_reg <= addr_oob ? '0 : mem[addr_idx];
            end
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
          end else begin
            valid_reg <= g_stage[gi-1].valid_reg;
            if (g_stage[gi-1].valid_reg) begin
              data_reg <= g_stage[gi-1].data_reg;
            end
          end
        end
      end

      assign pipe_valid[gi] = valid_reg;
    end
  endgenerate

  assign p0.rd_valid = pipe_valid[RD_LATENCY-1];
  assign p0.rd_data  = g_stage[RD_LATENCY-1].data_reg;
  assign dump_data   = dump_word_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      init_ready    <= 1'b1;
      serve         <= 1'b0;
      dump_valid    <= 1'b0;
      dump_last     <= 1'b0;
      err           <= 1'b0;
      cnt_reg       <= '0;
      dcnt_reg      <= '0;
      wait_reg      <= '0;
      dump_pend_reg <= 1'b0;
    end else begin
      if (proto_err) begin
        err <= 1'b1;
      end
      case (state_reg)
        ST_INIT: begin
          if (init_bypass) begin
            state_reg  <= ST_SERVE;
            init_ready <= 1'b0;
            serve      <= 1'b1;
            cnt_reg    <= '0;
          end else if (init_valid) begin
            if (cnt_reg == LAST_IDX) begin
              state_reg  <= ST_SERVE;
              init_ready <= 1'b0;
              serve      <= 1'b1;
              cnt_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (dump_start) begin
            dump_pend_reg <= 1'b1;
          end
          if (dump_go) begin
            state_reg     <= ST_DUMP_RD;
            serve         <= 1'b0;
            dump_pend_reg <= 1'b0;
            wait_reg      <= '0;
          end
        end
        ST_DUMP_RD: begin
          if (wait_reg == WAIT_END) begin
            state_reg  <= ST_DUMP_OUT;
            dump_valid <= 1'b1;
            dump_last  <= (dcnt_reg == LAST_IDX);
            wait_reg   <= '0;
          end else begin
            wait_reg <= wait_reg + 1'b1;
          end
        end
        ST_DUMP_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (dcnt_reg == LAST_IDX) begin
              dcnt_reg  <= '0;
              state_reg <= ST_SERVE;
              serve     <= 1'b1;
            end else begin
              dcnt_reg  <= dcnt_reg + 1'b1;
              state_reg <= ST_DUMP_RD;
            end
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

endmodule
